// File: rtl/hamming_sequencer.sv
// rtl/hamming_sequencer.sv - Hamming(7,4) demo sequencer: encode, inject, check, correct, show
module hamming_sequencer #(
    parameter int SHOW_CYCLES = 27_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [3:0] data_i,
    input  logic [2:0] err_pos_i,
    output logic [3:0] enc_data_o,
    input  logic [6:0] enc_word_i,
    output logic [6:0] chk_word_o,
    input  logic [2:0] syndrome_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [6:0] result_word_o,
    output logic [3:0] data_out_o,
    output logic [2:0] syndrome_o,
    output logic       err_flag_o
);

    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ENCODE  = 3'd2,
        S_INJECT  = 3'd3,
        S_CHECK   = 3'd4,
        S_CORRECT = 3'd5,
        S_SHOW    = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_data;
    logic [2:0]    r_pos;
    logic [6:0]    r_word;
    logic [2:0]    r_syn;
    logic [3:0]    r_enc_data;
    logic [6:0]    r_chk_word;
    logic [6:0]    r_result;
    logic [3:0]    r_data_out;
    logic [2:0]    r_syndrome;
    logic          r_err_flag;
    logic          r_done;
    logic          w_start_ok;
    logic [6:0]    w_injected;
    logic [6:0]    w_corrected;

    // Position 0 means "no bit"; 1..7 select codeword bit pos-1.
    function automatic logic [6:0] bit_mask(input logic [2:0] pos);
        if (pos == 3'd0)
            bit_mask = 7'd0;
        else
            bit_mask = 7'd1 << (pos - 3'd1);
    endfunction

    assign w_start_ok  = start_i && ((r_state == S_IDLE) || (r_state == S_SHOW));
    assign w_injected  = r_word ^ bit_mask(r_pos);
    assign w_corrected = r_word ^ bit_mask(r_syn);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = S_LOAD;
            S_LOAD:    w_next = S_ENCODE;
            S_ENCODE:  w_next = S_INJECT;
            S_INJECT:  w_next = S_CHECK;
            S_CHECK:   w_next = S_CORRECT;
            S_CORRECT: w_next = S_SHOW;
            S_SHOW: begin
                if (start_i)
                    w_next = S_LOAD;
                else if (r_cnt == '0)
                    w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Drive registers update one state ahead so each combinational path gets a full cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_data     <= '0;
            r_pos      <= '0;
            r_word     <= '0;
            r_syn      <= '0;
            r_enc_data <= '0;
            r_chk_word <= '0;
            r_result   <= '0;
            r_data_out <= '0;
            r_syndrome <= '0;
            r_err_flag <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_CORRECT);
            if (w_start_ok) begin
                r_data <= data_i;
                r_pos  <= err_pos_i;
            end
            case (r_state)
                S_LOAD:   r_enc_data <= r_data;
                S_ENCODE: r_word <= enc_word_i;
                S_INJECT: begin
                    r_word     <= w_injected;
                    r_chk_word <= w_injected;
                end
                S_CHECK:  r_syn <= syndrome_i;
                S_CORRECT: begin
                    r_result   <= w_corrected;
                    r_data_out <= {w_corrected[6:4], w_corrected[2]};
                    r_syndrome <= r_syn;
                    r_err_flag <= |r_syn;
                    r_cnt      <= CW'(SHOW_CYCLES - 1);
                end
                S_SHOW:   if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                default:  ;
            endcase
        end
    end

    assign enc_data_o    = r_enc_data;
    assign chk_word_o    = r_chk_word;
    assign busy_o        = (r_state == S_LOAD) || (r_state == S_ENCODE) || (r_state == S_INJECT) ||
                           (r_state == S_CHECK) || (r_state == S_CORRECT);
    assign done_o        = r_done;
    assign result_word_o = r_result;
    assign data_out_o    = r_data_out;
    assign syndrome_o    = r_syndrome;
    assign err_flag_o    = r_err_flag;

endmodule

// File: tb/tb_hamming_sequencer.sv
// tb/tb_hamming_sequencer.sv - scoreboard bench for hamming_sequencer with encoder/checker models
module tb_hamming_sequencer;

    localparam int SHOW_N = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SHOW = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] data_i;
    logic [2:0] err_pos_i;
    logic [3:0] enc_data_o;
    logic [6:0] enc_word_i;
    logic [6:0] chk_word_o;
    logic [2:0] syndrome_i;
    logic       busy_o;
    logic       done_o;
    logic [6:0] result_word_o;
    logic [3:0] data_out_o;
    logic [2:0] syndrome_o;
    logic       err_flag_o;

    typedef struct packed {
        logic [6:0] chk;
        logic [2:0] syn;
        logic       flag;
        logic [6:0] word;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic c0, c1, c2;
        c0 = d[0] ^ d[1] ^ d[3];
        c1 = d[0] ^ d[2] ^ d[3];
        c2 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], c2, d[0], c1, c0};
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] w);
        return {w[3] ^ w[4] ^ w[5] ^ w[6], w[1] ^ w[2] ^ w[5] ^ w[6], w[0] ^ w[2] ^ w[4] ^ w[6]};
    endfunction

    assign enc_word_i = encode(enc_data_o);
    assign syndrome_i = syndrome(chk_word_o);

    hamming_sequencer #(.SHOW_CYCLES(SHOW_N)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .data_i(data_i), .err_pos_i(err_pos_i),
        .enc_data_o(enc_data_o), .enc_word_i(enc_word_i), .chk_word_o(chk_word_o),
        .syndrome_i(syndrome_i), .busy_o(busy_o), .done_o(done_o),
        .result_word_o(result_word_o), .data_out_o(data_out_o), .syndrome_o(syndrome_o),
        .err_flag_o(err_flag_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] d, input logic [2:0] p, input bit push);
        exp_t e;
        logic [6:0] m;
        m = (p == 3'd0) ? 7'd0 : (7'd1 << (p - 3'd1));
        e.word = encode(d);
        e.chk  = e.word ^ m;
        e.syn  = p;
        e.flag = (p != 3'd0);
        e.data = d;
        if (push) sb.push_back(e);
        data_i    = d;
        err_pos_i = p;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (!done_o && lat < 30) begin
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, done_o, 1'b1);
        check({tag, "_latency"}, lat, 6);
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
        if (done_o && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_chk_word"}, chk_word_o, e.chk);
            check({tag, "_syndrome"}, syndrome_o, e.syn);
            check({tag, "_err_flag"}, err_flag_o, e.flag);
            check({tag, "_result"}, result_word_o, e.word);
            check({tag, "_data_out"}, data_out_o, e.data);
            check({tag, "_busy_in_show"}, busy_o, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {enc_data_o, chk_word_o, busy_o, done_o, result_word_o,
                               data_out_o, syndrome_o, err_flag_o}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start_i = 1'b0; data_i = 4'd0; err_pos_i = 3'd0;
        tick(); tick();
        check_all_zero("reset");
        check("reset_state", dut.r_state, ST_IDLE);

        start_op(4'b1111, 3'd0, 1'b0);
        check("rst_wins_busy", busy_o, 1'b0);
        rst = 1'b0;
        tick();

        start_op(4'b1011, 3'd0, 1'b1);
        check("busy_load", busy_o, 1'b1);
        wait_done("clean", 1);
        check("clean_enc_word", encode(4'b1011), 7'h55);
        tick();
        check("done_single", done_o, 1'b0);
        repeat (SHOW_N + 2) tick();

        start_op(4'b1011, 3'd5, 1'b1);
        wait_done("pos5", 1);
        repeat (SHOW_N + 2) tick();

        start_op(4'b0000, 3'd7, 1'b1);
        wait_done("pos7", 1);
        repeat (SHOW_N + 2) tick();

        start_op(4'b1101, 3'd3, 1'b1);
        tick(); tick();
        data_i = 4'b0000; err_pos_i = 3'd1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done("ignore", 4);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_o) n++;
        end
        check("ignore_no_second_done", n, 0);
        check("ignore_sb_empty", sb.size(), 0);

        start_op(4'b0101, 3'd2, 1'b1);
        wait_done("pre_restart", 1);
        tick();
        start_op(4'b0110, 3'd4, 1'b1);
        check("restart_busy", busy_o, 1'b1);
        wait_done("restart", 1);

        n = 1;
        while (dut.r_state == ST_SHOW && n < 20) begin
            tick();
            n++;
        end
        check("show_len", n - 1, SHOW_N);
        check("show_then_idle", dut.r_state, ST_IDLE);
        check("idle_result_kept", {result_word_o, data_out_o, syndrome_o, err_flag_o},
              {encode(4'b0110), 4'b0110, 3'd4, 1'b1});

        start_op(4'b1001, 3'd6, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_check");
        check("rst_check_state", dut.r_state, ST_IDLE);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_o) n++;
        end
        check("rst_no_publish", n, 0);

        start_op(4'b0011, 3'd1, 1'b1);
        wait_done("after_rst", 1);
        repeat (SHOW_N + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_sequencer.md
# hamming_sequencer

Control block for the Hamming(7,4) demonstration path. On a start pulse it latches the 4-bit switch data and an error-injection position, then drives the external encoder and captures its 7-bit codeword. It optionally flips one codeword bit, drives the syndrome checker and captures the syndrome, corrects the flagged bit, and holds the result for a fixed display window. It sits between the debounced user inputs and the encoder/checker/display datapath.

## Interface
- SHOW_CYCLES, 27_000_000: number of cycles the SHOW state holds before returning to IDLE; must be ≥ 1.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle start pulse, already debounced
- data_i  in  4  data nibble {i3,i2,i1,i0}
- err_pos_i  in  3  0 = no injection; 1..7 = flip codeword bit (err_pos_i−1)
- enc_data_o  out  4  latched nibble driven to the encoder
- enc_word_i  in  7  encoder codeword {i3,i2,i1,c2,i0,c1,c0} (bits 6..0)
- chk_word_o  out  7  (possibly corrupted) word driven to the syndrome checker
- syndrome_i  in  3  checker syndrome {s2,s1,s0}; value = 1-based error position
- busy_o  out  1  high in LOAD, ENCODE, INJECT, CHECK, CORRECT
- done_o  out  1  one-cycle pulse, first cycle of SHOW
- result_word_o  out  7  corrected codeword
- data_out_o  out  4  corrected data {w6,w5,w4,w2}
- syndrome_o  out  3  latched syndrome
- err_flag_o  out  1  latched (syndrome ≠ 0)

## Operation
- States: IDLE, LOAD, ENCODE, INJECT, CHECK, CORRECT, SHOW.
- IDLE: when start_i is high, latch data_i→data_r and err_pos_i→pos_r, then go to LOAD.
- LOAD: enc_data_o = data_r; this cycle is the encoder settle cycle. Go to ENCODE.
- ENCODE: capture word_r ← enc_word_i on exit. Go to INJECT.
- INJECT: if pos_r ≠ 0, word_r ← word_r ^ (1 << (pos_r−1)); otherwise word_r is unchanged. Go to CHECK.
- CHECK: chk_word_o = word_r; capture syn_r ← syndrome_i on exit. Go to CORRECT.
- CORRECT: on exit, update the outputs, then go to SHOW.
  - result_word_o ← word_r ^ (syn_r ≠ 0 ? 1 << (syn_r−1) : 0)
  - data_out_o ← corrected {w6,w5,w4,w2}
  - syndrome_o ← syn_r
  - err_flag_o ← |syn_r
- SHOW: load counter with SHOW_CYCLES−1 on entry; decrement each cycle; at 0 go to IDLE.
- Start handling:
  - start_i high in SHOW: abort the hold, latch new inputs, go to LOAD.
  - start_i in LOAD..CORRECT: ignored, not queued.
- enc_data_o and chk_word_o hold their last registered value in all states.
- Result outputs change only on CORRECT exit. They persist through SHOW and IDLE until the next CORRECT exit.
- Only a single-bit error is corrected. No double-error detection is provided.

## Timing
- Reset (sync): state IDLE, counter 0. Every output is 0: enc_data_o, chk_word_o, busy_o, done_o, result_word_o, data_out_o, syndrome_o, err_flag_o.
- rst wins over start_i in the same cycle.
- rst asserted in any state aborts the operation at that edge; no partial result is published.
- Start sampled at edge k gives these transitions:
  - LOAD at k+1, ENCODE k+2, INJECT k+3, CHECK k+4, CORRECT k+5, SHOW k+6.
  - busy_o is high for cycles k+1..k+5.
  - Results are valid and done_o = 1 in the cycle after edge k+5. Start-to-result latency is 6 cycles.
- The encoder and checker paths are combinational. Each gets exactly one full cycle between the registered drive and the capture edge.
- SHOW lasts SHOW_CYCLES cycles, then IDLE. A start in the last SHOW cycle takes priority over the timeout.
- done_o is never high in two consecutive cycles.

## Test plan
- data_i=4'b1011, err_pos_i=0, bench encoder/checker models → enc_word 7'h55, syndrome_o=0, err_flag_o=0, result_word_o=7'h55, data_out_o=4'b1011; done_o pulses 6 cycles after start.
- data_i=4'b1011, err_pos_i=5 → chk_word_o=7'h45, syndrome_o=3'd5, err_flag_o=1, result_word_o=7'h55, data_out_o=4'b1011.
- data_i=4'b0000, err_pos_i=7 → chk_word_o=7'h40, syndrome_o=3'd7, result_word_o=7'h00, data_out_o=4'b0000.
- start_i pulsed again during INJECT → ignored, single done_o. Start pulsed in SHOW with data_i=4'b0110 → restart, new result data_out_o=4'b0110 after 6 cycles.
- rst asserted in CHECK → next cycle IDLE, all outputs 0. A subsequent start completes normally.
- SHOW_CYCLES=4, no further start → SHOW for exactly 4 cycles, then IDLE with result outputs unchanged.
